a2d_spi_resp: RTL

SPI responder (slave-side model) of the 8-channel, 12-bit A2D serial interface. It decodes the channel command the A2D master shifts in on MOSI and returns that channel's conversion value on MISO in the following 16-bit frame. Per-channel values are written by a host/bench port. The block sits opposite the A2D interface master in system-level simulation and on FPGA bring-up boards.

---
 rtl/a2d_spi_resp.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp: SPI responder for the 8-channel, 12-bit A2D serial link.
// It decodes the channel number in each 16-bit command frame shifted in on
// MOSI, and returns that channel's stored value on MISO in the next frame.
// Channel values are loaded through a simple host write port.
module a2d_spi_resp #(
    parameter bit          INVERT  = 1'b1,
    parameter logic [11:0] RST_VAL = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic        wr_en,
    input  logic [2:0]  wr_chnnl,
    input  logic [11:0] wr_data,
    output logic        frame_done,
    output logic [15:0] rx_cmd,
    output logic [2:0]  cur_chnnl,
    output logic        busy
);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    state_t      state_q, state_d;

    // Synchronizer stages and the previous SCLK sample used for edge detection.
    logic        ss_meta_q, ss_sync_q;
    logic        sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic        mosi_meta_q, mosi_sync_q;
    logic        sclk_rise, sclk_fall;

    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] rx_sr_q, rx_sr_d;
    logic [15:0] tx_sr_q, tx_sr_d;
    logic [15:0] rx_cmd_q, rx_cmd_d;
    logic [2:0]  cur_chnnl_q, cur_chnnl_d;
    logic        frame_done_q, frame_done_d;

    logic [11:0] data_q [8];
    logic [11:0] tx_word;

    // Two-flop synchronizers for the master's signals. SS_n resets to the
    // "selected" level so a transaction already in flight when reset drops
    // is held off in WAIT_IDLE until SS_n is genuinely seen high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss_meta_q   <= 1'b0;
            ss_sync_q   <= 1'b0;
            sclk_meta_q <= 1'b1;
            sclk_sync_q <= 1'b1;
            sclk_prev_q <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            ss_meta_q   <= SS_n;
            ss_sync_q   <= ss_meta_q;
            sclk_meta_q <= SCLK;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            mosi_meta_q <= MOSI;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q;

    // Response word for the currently selected channel; the read sees the
    // register before any same-cycle host write lands.
    assign tx_word = INVERT ? ~data_q[cur_chnnl_q] : data_q[cur_chnnl_q];

    // Per-channel conversion values, writable in any state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                data_q[i] <= RST_VAL;
            end
        end else if (wr_en) begin
            data_q[wr_chnnl] <= wr_data;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= WAIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath update: receive on SCLK rise, transmit on fall.
    // Within IDLE and ACTIVE the synchronized SS_n level stands in for its
    // edges, since each state is only entered with SS_n at the opposite level.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_sr_d      = rx_sr_q;
        tx_sr_d      = tx_sr_q;
        rx_cmd_d     = rx_cmd_q;
        cur_chnnl_d  = cur_chnnl_q;
        frame_done_d = 1'b0;

        case (state_q)
            WAIT_IDLE: begin
                if (ss_sync_q) begin
                    state_d = IDLE;
                end
            end

            IDLE: begin
                if (!ss_sync_q) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = '0;
                end
            end

            ACTIVE: begin
                if (ss_sync_q) begin
                    // End of transaction; any partial frame is dropped.
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else begin
                    if (sclk_rise) begin
                        rx_sr_d   = {rx_sr_q[14:0], mosi_sync_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd15) begin
                            rx_cmd_d     = rx_sr_d;
                            cur_chnnl_d  = rx_sr_d[13:11];
                            frame_done_d = 1'b1;
                        end
                    end
                    if (sclk_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            tx_sr_d = {4'b0000, tx_word};
                        end else begin
                            tx_sr_d = {tx_sr_q[14:0], 1'b0};
                        end
                    end
                end
            end

            default: begin
                state_d = WAIT_IDLE;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_q    <= '0;
            rx_sr_q      <= '0;
            tx_sr_q      <= '0;
            rx_cmd_q     <= '0;
            cur_chnnl_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            rx_sr_q      <= rx_sr_d;
            tx_sr_q      <= tx_sr_d;
            rx_cmd_q     <= rx_cmd_d;
            cur_chnnl_q  <= cur_chnnl_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign MISO       = (state_q == ACTIVE) & tx_sr_q[15];
    assign busy       = (state_q == ACTIVE);
    assign frame_done = frame_done_q;
    assign rx_cmd     = rx_cmd_q;
    assign cur_chnnl  = cur_chnnl_q;

endmodule
